reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised two-read / two-write register file with per-register busy scoreboard, optional write-to-read bypass and a hardwired zero register. It replaces the single-write-port register file in the pipeline decode stage. It serves the decode stage's two operand reads and accepts writeback from two retiring lanes. Each register carries a busy bit, set when decode claims the register as a destination and cleared on writeback, so decode can detect RAW hazards without a separate scoreboard.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W
- ZERO_REG, 1, 1 = entry 0 reads 0, ignores writes and claims, never busy
- BYPASS, 1, 1 = same-cycle writes and claims are forwarded to reads; 0 = reads return pre-update state

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- Read_Reg1, Read_Reg2  in  ADDR_W  read addresses
- Read_Data1, Read_Data2  out  DATA_W  registered read data
- Read_Busy1, Read_Busy2  out  1  registered busy bit of the addressed register
- Write_Reg0, Write_Reg1  in  ADDR_W  writeback addresses, lanes 0 and 1
- Write_Data0, Write_Data1  in  DATA_W  writeback data
- Reg_Write0, Reg_Write1  in  1  writeback enables
- Claim_Reg  in  ADDR_W  destination being issued
- Claim_En  in  1  set busy on Claim_Reg
- Flush  in  1  clear all busy bits
- Busy_Count  out  ADDR_W+1  number of busy registers, registered

## Operation
- All state updates on the rising edge of Clk.
- Writes: lane enabled → entry[Write_RegN] <= Write_DataN.
  - Both lanes to the same address: lane 1 wins.
  - ZERO_REG=1 and address 0: the write is discarded.
- Busy clear: an enabled write clears busy[Write_RegN].
- Busy set: Claim_En sets busy[Claim_Reg].
  - Claim and write to the same register in the same cycle: busy ends set. The claim is the newer producer. The write data is still stored.
- Flush: all busy bits clear in that cycle. A claim in the same cycle is ignored. Writes in the same cycle still store data.
- ZERO_REG=1: a claim on register 0 is ignored.
- Reads, BYPASS=1:
  - Read_DataN <= the data the entry holds after this cycle's writes (lane 1 over lane 0 over array).
  - Read_BusyN <= the busy bit after this cycle's claim, write and flush updates.
- Reads, BYPASS=0:
  - Read_DataN <= array contents before this cycle's writes.
  - Read_BusyN <= busy bit before this cycle's updates.
- Address 0 with ZERO_REG=1: Read_DataN <= 0 and Read_BusyN <= 0, regardless of writes.
- Both read ports are independent and may address the same register.
- Busy_Count always equals the popcount of the busy array as registered in the same cycle. Its range is 0 to 2^ADDR_W. It cannot wrap.

## Timing
- Read latency: 1 cycle. An address presented before edge k appears on Read_Data/Read_Busy after edge k.
- Write latency: data is stored at edge k.
  - BYPASS=1: a read issued in the same cycle returns it after edge k.
  - BYPASS=0: the first read that returns it is issued in the next cycle.
- Claim, write-clear and Flush take effect at the edge. Busy_Count reflects them after that same edge.
- Reset: Rst high asynchronously forces the following to 0 and holds them while high:
  - all entries
  - all busy bits
  - Read_Data1/2, Read_Busy1/2
  - Busy_Count
- Reset asserted mid-operation discards all in-flight writes and claims. Deassertion is synchronous to Clk by the system. The first edge after deassertion behaves normally.
- No handshake. Every input is sampled every cycle. There are no stall or back-pressure outputs.

## Test plan
- Reset then read: Rst pulse, Read_Reg1=3, Read_Reg2=0 → Read_Data1=0, Read_Data2=0, Busy_Count=0. Entries stay 0 after deassert.
- Write/read and zero register: Write lane0 reg 2 = 6 in cycle 1, read reg 2 in cycle 2 → 6. Write reg 0 = 0xFFFFFFFF, then read reg 0 → 0 (ZERO_REG=1).
- Bypass and lane priority: same cycle lane0 reg 5 = 0x11, lane1 reg 5 = 0x22, Read_Reg1=5.
  - BYPASS=1 → 0x22 after that edge.
  - BYPASS=0 → old value (0), then 0x22 on the next read.
- Scoreboard: claim reg 7 → Read_Busy for reg 7 =1, Busy_Count=1. Claim reg 9 → Busy_Count=2. Write reg 7 → busy 0, Busy_Count=1. Claim and write reg 9 in the same cycle → busy stays 1, data stored.
- Flush vs claim: regs 1, 2, 3 busy (Busy_Count=3), then Flush with Claim_En reg 4 → all busy 0, Busy_Count=0. Claim reg 0 → Busy_Count stays 0.
- Async reset mid-stream: assert Rst between edges while regs 1–3 are busy and reg 1=0x55 → outputs 0 immediately, without a clock edge. After release, reg 1 reads 0 and Busy_Count=0.

Source files
------------

// File: rtl/reg_file_sb.sv
// Two-read / two-write register file with a per-register busy scoreboard,
// optional same-cycle bypass to the read ports and an optional hardwired zero entry.
module reg_file_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] Read_Reg1,
    input  logic [ADDR_W-1:0] Read_Reg2,
    output logic [DATA_W-1:0] Read_Data1,
    output logic [DATA_W-1:0] Read_Data2,
    output logic              Read_Busy1,
    output logic              Read_Busy2,
    input  logic [ADDR_W-1:0] Write_Reg0,
    input  logic [ADDR_W-1:0] Write_Reg1,
    input  logic [DATA_W-1:0] Write_Data0,
    input  logic [DATA_W-1:0] Write_Data1,
    input  logic              Reg_Write0,
    input  logic              Reg_Write1,
    input  logic [ADDR_W-1:0] Claim_Reg,
    input  logic              Claim_En,
    input  logic              Flush,
    output logic [ADDR_W:0]   Busy_Count
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   count_d;
    logic [DATA_W-1:0] rdata1_d, rdata2_d;
    logic              rbusy1_d, rbusy2_d;

    // Order matters: lane 1 overrides lane 0, a claim overrides a write-clear,
    // and flush overrides everything on the busy array.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (Reg_Write0) begin
            mem_d[Write_Reg0]  = Write_Data0;
            busy_d[Write_Reg0] = 1'b0;
        end
        if (Reg_Write1) begin
            mem_d[Write_Reg1]  = Write_Data1;
            busy_d[Write_Reg1] = 1'b0;
        end
        if (Claim_En) begin
            busy_d[Claim_Reg] = 1'b1;
        end
        if (Flush) begin
            busy_d = '0;
        end
        if (ZERO_REG) begin
            mem_d[0]  = '0;
            busy_d[0] = 1'b0;
        end
    end

    always_comb begin
        if (BYPASS) begin
            rdata1_d = mem_d[Read_Reg1];
            rdata2_d = mem_d[Read_Reg2];
            rbusy1_d = busy_d[Read_Reg1];
            rbusy2_d = busy_d[Read_Reg2];
        end else begin
            rdata1_d = mem_q[Read_Reg1];
            rdata2_d = mem_q[Read_Reg2];
            rbusy1_d = busy_q[Read_Reg1];
            rbusy2_d = busy_q[Read_Reg2];
        end
        if (ZERO_REG && (Read_Reg1 == '0)) begin
            rdata1_d = '0;
            rbusy1_d = 1'b0;
        end
        if (ZERO_REG && (Read_Reg2 == '0)) begin
            rdata2_d = '0;
            rbusy2_d = 1'b0;
        end
    end

    // Counted from the next-state array so the count lines up with busy_q.
    always_comb begin
        count_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            count_d = count_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q     <= '0;
            Read_Data1 <= '0;
            Read_Data2 <= '0;
            Read_Busy1 <= 1'b0;
            Read_Busy2 <= 1'b0;
            Busy_Count <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            busy_q     <= busy_d;
            Read_Data1 <= rdata1_d;
            Read_Data2 <= rdata2_d;
            Read_Busy1 <= rbusy1_d;
            Read_Busy2 <= rbusy2_d;
            Busy_Count <= count_d;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed vector bench for reg_file_sb; drives a bypassing and a non-bypassing
// instance with the same stimulus and checks both against hand-computed values.
module tb_reg_file_sb;

    logic        Clk;
    logic        Rst;
    logic [4:0]  Read_Reg1, Read_Reg2, Write_Reg0, Write_Reg1, Claim_Reg;
    logic [31:0] Write_Data0, Write_Data1;
    logic        Reg_Write0, Reg_Write1, Claim_En, Flush;

    logic [31:0] b_data1, b_data2, n_data1, n_data2;
    logic        b_busy1, b_busy2, n_busy1, n_busy2;
    logic [5:0]  b_count, n_count;

    int errors = 0;
    int checks = 0;

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_byp (
        .Clk(Clk), .Rst(Rst),
        .Read_Reg1(Read_Reg1), .Read_Reg2(Read_Reg2),
        .Read_Data1(b_data1), .Read_Data2(b_data2),
        .Read_Busy1(b_busy1), .Read_Busy2(b_busy2),
        .Write_Reg0(Write_Reg0), .Write_Reg1(Write_Reg1),
        .Write_Data0(Write_Data0), .Write_Data1(Write_Data1),
        .Reg_Write0(Reg_Write0), .Reg_Write1(Reg_Write1),
        .Claim_Reg(Claim_Reg), .Claim_En(Claim_En), .Flush(Flush),
        .Busy_Count(b_count)
    );

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_nob (
        .Clk(Clk), .Rst(Rst),
        .Read_Reg1(Read_Reg1), .Read_Reg2(Read_Reg2),
        .Read_Data1(n_data1), .Read_Data2(n_data2),
        .Read_Busy1(n_busy1), .Read_Busy2(n_busy2),
        .Write_Reg0(Write_Reg0), .Write_Reg1(Write_Reg1),
        .Write_Data0(Write_Data0), .Write_Data1(Write_Data1),
        .Reg_Write0(Reg_Write0), .Reg_Write1(Reg_Write1),
        .Claim_Reg(Claim_Reg), .Claim_En(Claim_En), .Flush(Flush),
        .Busy_Count(n_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]  rd1, rd2, wr0, wr1, cr;
        logic [31:0] wd0, wd1;
        logic        we0, we1, ce, fl;
        logic [31:0] d1, d2, nd1;
        logic        b1, b2, nb1;
        logic [5:0]  cnt;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(
        input logic [31:0] rd1, rd2, wr0, wd0, we0, wr1, wd1, we1, cr, ce, fl,
        input logic [31:0] d1, d2, b1, b2, cnt, nd1, nb1
    );
        vec_t v;
        v.rd1 = rd1[4:0]; v.rd2 = rd2[4:0];
        v.wr0 = wr0[4:0]; v.wd0 = wd0;     v.we0 = we0[0];
        v.wr1 = wr1[4:0]; v.wd1 = wd1;     v.we1 = we1[0];
        v.cr  = cr[4:0];  v.ce  = ce[0];   v.fl  = fl[0];
        v.d1  = d1;       v.d2  = d2;      v.b1  = b1[0];  v.b2 = b2[0];
        v.cnt = cnt[5:0]; v.nd1 = nd1;     v.nb1 = nb1[0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        Read_Reg1 = '0;  Read_Reg2 = '0;
        Write_Reg0 = '0; Write_Data0 = '0; Reg_Write0 = 1'b0;
        Write_Reg1 = '0; Write_Data1 = '0; Reg_Write1 = 1'b0;
        Claim_Reg = '0;  Claim_En = 1'b0;  Flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " b_data1"}, b_data1, 32'h0);
        chk({tag, " b_data2"}, b_data2, 32'h0);
        chk({tag, " b_busy"}, {30'h0, b_busy1, b_busy2}, 32'h0);
        chk({tag, " b_count"}, 32'(b_count), 32'h0);
        chk({tag, " n_data1"}, n_data1, 32'h0);
        chk({tag, " n_count"}, 32'(n_count), 32'h0);
    endtask

    initial begin
        //            rd1 rd2 wr0 wd0        we0 wr1 wd1 we1 cr ce fl | d1 d2 b1 b2 cnt | nd1 nb1
        vecs[0]  = mk(3,  0,  0,  0,          0, 0,  0,  0,  0, 0, 0,  0,    0,    0, 0, 0,  0,    0);
        vecs[1]  = mk(2,  2,  2,  6,          1, 0,  0,  0,  0, 0, 0,  6,    6,    0, 0, 0,  0,    0);
        vecs[2]  = mk(2,  0,  0,  0,          0, 0,  0,  0,  0, 0, 0,  6,    0,    0, 0, 0,  6,    0);
        vecs[3]  = mk(0,  0,  0,  32'hFFFFFFFF, 1, 0, 0, 0,  0, 0, 0,  0,    0,    0, 0, 0,  0,    0);
        vecs[4]  = mk(0,  2,  0,  0,          0, 0,  0,  0,  0, 0, 0,  0,    6,    0, 0, 0,  0,    0);
        vecs[5]  = mk(5,  5,  5,  'h11,       1, 5,  'h22, 1, 0, 0, 0, 'h22, 'h22, 0, 0, 0,  0,    0);
        vecs[6]  = mk(5,  2,  0,  0,          0, 0,  0,  0,  0, 0, 0, 'h22, 6,    0, 0, 0, 'h22,  0);
        vecs[7]  = mk(7,  7,  0,  0,          0, 0,  0,  0,  7, 1, 0,  0,    0,    1, 1, 1,  0,    0);
        vecs[8]  = mk(7,  9,  0,  0,          0, 0,  0,  0,  9, 1, 0,  0,    0,    1, 1, 2,  0,    1);
        vecs[9]  = mk(7,  9,  0,  0,          0, 7,  'h77, 1, 0, 0, 0, 'h77, 0,    0, 1, 1,  0,    1);
        vecs[10] = mk(9,  7,  9,  'h99,       1, 0,  0,  0,  9, 1, 0, 'h99, 'h77, 1, 0, 1,  0,    1);
        vecs[11] = mk(9,  7,  0,  0,          0, 0,  0,  0,  0, 0, 0, 'h99, 'h77, 1, 0, 1, 'h99,  1);
        vecs[12] = mk(1,  9,  0,  0,          0, 0,  0,  0,  1, 1, 0,  0,   'h99, 1, 1, 2,  0,    0);
        vecs[13] = mk(2,  1,  0,  0,          0, 0,  0,  0,  2, 1, 0,  6,    0,    1, 1, 3,  6,    0);
        vecs[14] = mk(3,  2,  0,  0,          0, 0,  0,  0,  3, 1, 0,  0,    6,    1, 1, 4,  0,    0);
        vecs[15] = mk(3,  4,  4,  'h44,       1, 0,  0,  0,  4, 1, 1,  0,   'h44, 0, 0, 0,  0,    1);
        vecs[16] = mk(0,  4,  0,  0,          0, 0,  0,  0,  0, 1, 0,  0,   'h44, 0, 0, 0,  0,    0);
        vecs[17] = mk(1,  3,  1,  'h55,       1, 0,  0,  0,  1, 1, 0, 'h55, 0,    1, 0, 1,  0,    0);
        vecs[18] = mk(10, 11, 10, 'hA,        1, 11, 'hB, 1, 0, 0, 0, 'hA,  'hB,  0, 0, 1,  0,    0);

        // Reset with the test-plan read addresses applied.
        idle();
        Rst = 1'b1;
        Read_Reg1 = 5'd3;
        repeat (2) tick();
        chk_all_zero("reset");
        @(negedge Clk);
        Rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge Clk);
            Read_Reg1 = vecs[i].rd1;  Read_Reg2 = vecs[i].rd2;
            Write_Reg0 = vecs[i].wr0; Write_Data0 = vecs[i].wd0; Reg_Write0 = vecs[i].we0;
            Write_Reg1 = vecs[i].wr1; Write_Data1 = vecs[i].wd1; Reg_Write1 = vecs[i].we1;
            Claim_Reg = vecs[i].cr;   Claim_En = vecs[i].ce;     Flush = vecs[i].fl;
            tick();
            chk($sformatf("row%0d b_data1", i), b_data1, vecs[i].d1);
            chk($sformatf("row%0d b_data2", i), b_data2, vecs[i].d2);
            chk($sformatf("row%0d b_busy1", i), 32'(b_busy1), 32'(vecs[i].b1));
            chk($sformatf("row%0d b_busy2", i), 32'(b_busy2), 32'(vecs[i].b2));
            chk($sformatf("row%0d b_count", i), 32'(b_count), 32'(vecs[i].cnt));
            chk($sformatf("row%0d n_data1", i), n_data1, vecs[i].nd1);
            chk($sformatf("row%0d n_busy1", i), 32'(n_busy1), 32'(vecs[i].nb1));
            chk($sformatf("row%0d n_count", i), 32'(n_count), 32'(vecs[i].cnt));
        end

        // Async reset mid-stream: regs 1..3 busy, reg 1 holds 0x55.
        @(negedge Clk);
        idle();
        Read_Reg1 = 5'd1; Claim_Reg = 5'd2; Claim_En = 1'b1;
        tick();
        chk("pre-rst count2", 32'(b_count), 32'd2);
        @(negedge Clk);
        Claim_Reg = 5'd3;
        tick();
        chk("pre-rst count3", 32'(b_count), 32'd3);
        chk("pre-rst b_data1", b_data1, 32'h55);
        chk("pre-rst n_data1", n_data1, 32'h55);
        @(negedge Clk);
        Claim_Reg = 5'd4;
        Write_Reg0 = 5'd5; Write_Data0 = 32'h5A; Reg_Write0 = 1'b1;
        #2;
        Rst = 1'b1;
        #1;
        chk_all_zero("async-rst");
        tick();
        chk_all_zero("rst-held");
        @(negedge Clk);
        Rst = 1'b0;
        idle();
        Read_Reg1 = 5'd1; Read_Reg2 = 5'd5;
        tick();
        chk_all_zero("post-rst");
        chk("post-rst n_busy1", 32'(n_busy1), 32'h0);

        // Fill the scoreboard: count tops out at 31 with entry 0 hardwired.
        for (int r = 1; r < 32; r++) begin
            @(negedge Clk);
            idle();
            Claim_Reg = 5'(r); Claim_En = 1'b1;
            tick();
        end
        chk("full b_count", 32'(b_count), 32'd31);
        chk("full n_count", 32'(n_count), 32'd31);
        @(negedge Clk);
        idle();
        Claim_Reg = 5'd0; Claim_En = 1'b1; Read_Reg1 = 5'd0; Read_Reg2 = 5'd31;
        tick();
        chk("claim0 b_count", 32'(b_count), 32'd31);
        chk("claim0 b_busy1", 32'(b_busy1), 32'h0);
        chk("claim0 b_busy2", 32'(b_busy2), 32'h1);
        chk("claim0 n_busy2", 32'(n_busy2), 32'h1);
        @(negedge Clk);
        idle();
        Flush = 1'b1; Read_Reg1 = 5'd31;
        tick();
        chk("flush b_count", 32'(b_count), 32'd0);
        chk("flush b_busy1", 32'(b_busy1), 32'h0);
        chk("flush n_busy1", 32'(n_busy1), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
